// File: rtl/lmsm_pkg.sv
// lmsm_pkg: shared types and defaults for the load/store-multiple sequencer.
//   state_e   - sequencer FSM states
//   DEF_NREG  - default architectural register count (mask width)
//   DEF_AW    - default memory address width
package lmsm_pkg;
  localparam int DEF_NREG = 8;
  localparam int DEF_AW   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/lmsm_sequencer_if.sv
// lmsm_sequencer_if: command + memory + register-file signals of the sequencer.
//   master : command issuer / memory model (drives start, mask, mem_ready ...)
//   slave  : the sequencer (drives mem_req, rf_*, busy, done, xfer_count)
interface lmsm_sequencer_if
  import lmsm_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW,
  parameter int CW   = $clog2(NREG + 1)
);
  logic                    start;
  logic                    is_store;
  logic [NREG-1:0]         mask;
  logic [AW-1:0]           base_addr;
  logic                    abort;
  logic                    mem_ready;
  logic                    mem_req;
  logic                    mem_we;
  logic [AW-1:0]           mem_addr;
  logic [$clog2(NREG)-1:0] rf_raddr;
  logic [$clog2(NREG)-1:0] rf_waddr;
  logic                    rf_wen;
  logic                    busy;
  logic                    done;
  logic [CW-1:0]           xfer_count;

  modport master (
    output start, is_store, mask, base_addr, abort, mem_ready,
    input  mem_req, mem_we, mem_addr, rf_raddr, rf_waddr, rf_wen,
           busy, done, xfer_count
  );
  modport slave (
    input  start, is_store, mask, base_addr, abort, mem_ready,
    output mem_req, mem_we, mem_addr, rf_raddr, rf_waddr, rf_wen,
           busy, done, xfer_count
  );
endinterface

// File: rtl/lowest_set_idx.sv
// lowest_set_idx: index of the lowest set bit of vec (0 when vec is empty).
//   vec : NREG-bit input bitmap
//   idx : index of lowest set bit
module lowest_set_idx #(
  parameter int NREG = 8
) (
  input  logic [NREG-1:0]         vec,
  output logic [$clog2(NREG)-1:0] idx
);
  // Scan high to low so the last hit (lowest bit) wins.
  always_comb begin
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--)
      if (vec[i]) idx = ($clog2(NREG))'(i);
  end
endmodule

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: walks a register mask issuing one memory beat per set bit,
// lowest register first, at consecutive addresses from base_addr.
//   clk      : clock
//   proc_rst : asynchronous active-low reset
//   bus      : command / memory / register-file signals (slave side)
module lmsm_sequencer
  import lmsm_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW,
  parameter int CW   = $clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            proc_rst,
  lmsm_sequencer_if.slave bus
);
  localparam int IW = $clog2(NREG);

  state_e          state_q, state_d;
  logic [NREG-1:0] rem_mask_q, rem_mask_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            store_q, store_d;
  logic [IW-1:0]   widx_q, widx_d;
  logic [IW-1:0]   idx;
  logic [NREG-1:0] rem_clr;

  lowest_set_idx #(.NREG(NREG)) u_lsi (.vec(rem_mask_q), .idx(idx));

  assign rem_clr = rem_mask_q & ~(NREG'(1) << idx);

  always_comb begin
    state_d    = state_q;
    rem_mask_d = rem_mask_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    store_d    = store_q;
    widx_d     = widx_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) begin
        cnt_d = '0;
        if (bus.mask != '0) begin
          rem_mask_d = bus.mask;
          addr_d     = bus.base_addr;
          store_d    = bus.is_store;
          state_d    = ST_REQ;
        end else begin
          state_d = ST_DONE;
        end
      end
      // abort wins over mem_ready: the beat in flight is not counted.
      ST_REQ: if (bus.abort) begin
        state_d = ST_IDLE;
      end else if (bus.mem_ready) begin
        rem_mask_d = rem_clr;
        addr_d     = addr_q + AW'(1);
        cnt_d      = cnt_q + CW'(1);
        if (store_q) begin
          state_d = (rem_clr == '0) ? ST_DONE : ST_REQ;
        end else begin
          widx_d  = idx;
          state_d = ST_WB;
        end
      end
      ST_WB:   state_d = bus.abort ? ST_IDLE :
                         (rem_mask_q == '0) ? ST_DONE : ST_REQ;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      state_q    <= ST_IDLE;
      rem_mask_q <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      store_q    <= 1'b0;
      widx_q     <= '0;
    end else begin
      state_q    <= state_d;
      rem_mask_q <= rem_mask_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      store_q    <= store_d;
      widx_q     <= widx_d;
    end
  end

  // Outputs decode only flopped state; index/address buses are zeroed
  // outside the state that qualifies them.
  assign bus.mem_req    = (state_q == ST_REQ);
  assign bus.mem_we     = bus.mem_req & store_q;
  assign bus.mem_addr   = bus.mem_req ? addr_q : '0;
  assign bus.rf_raddr   = (bus.mem_req && store_q) ? idx : '0;
  assign bus.rf_wen     = (state_q == ST_WB);
  assign bus.rf_waddr   = bus.rf_wen ? widx_q : '0;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.xfer_count = cnt_q;
endmodule
